// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StSt,
        StOp,
        StPhyad,
        StRegad,
        StTa,
        StData
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_PATTERN = 2'b01;
    localparam logic [1:0] TA_WRITE   = 2'b10;

    localparam int unsigned PREAMBLE_LEN = 32;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned PHYAD_W = 5;
    localparam int unsigned REGAD_W = 5;
    localparam int unsigned TA_W    = 2;
    localparam int unsigned DATA_W  = 16;

    localparam logic [15:0] REG0_RST   = 16'h1140;
    localparam logic [15:0] REG1_VAL   = 16'h7949;
    localparam logic [15:0] REG2_VAL   = 16'h0022;
    localparam logic [15:0] REG3_VAL   = 16'h1622;
    localparam logic [15:0] REG_RW_RST = 16'h0000;

    function automatic logic [15:0] reg_reset_val(input logic [2:0] idx);
        unique case (idx)
            3'd0:    return REG0_RST;
            3'd1:    return REG1_VAL;
            3'd2:    return REG2_VAL;
            3'd3:    return REG3_VAL;
            default: return REG_RW_RST;
        endcase
    endfunction

    function automatic logic reg_is_rw(input logic [4:0] addr);
        return (addr == 5'd0) || (addr >= 5'd4 && addr <= 5'd7);
    endfunction

endpackage

// File: rtl/mdio_responder_if.sv
// Register-write and status bus presented by the MDIO responder.
interface mdio_responder_if;
    import mdio_pkg::*;

    logic               reg_wr;
    logic [REGAD_W-1:0] reg_addr;
    logic [DATA_W-1:0]  reg_wdata;
    logic               busy;
    logic               mdio_oe;

    modport master (output reg_wr, reg_addr, reg_wdata, busy, mdio_oe);
    modport slave  (input  reg_wr, reg_addr, reg_wdata, busy, mdio_oe);

endinterface

// File: rtl/mdio_regfile.sv
// 8x16 PHY register file: RW regs 0 and 4-7, RO ID regs 1-3, 8-31 read as zero.
module mdio_regfile
    import mdio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [4:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem_q [8];

    // RO entries are reloaded on soft reset too; they never take a write.
    always_ff @(posedge clk) begin
        if (!rst_n || soft_rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= reg_reset_val(3'(i));
            end
        end else if (we && reg_is_rw(waddr)) begin
            mem_q[waddr[2:0]] <= (waddr == 5'd0) ? {1'b0, wdata[14:0]} : wdata;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (raddr[4:3] == 2'b00) begin
            rdata = mem_q[raddr[2:0]];
        end
    end

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY responder: oversampled framing on CLK, tristate MDIO, register file.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               MDC,
    inout  wire                MDIO,
    mdio_responder_if.master   bus
);

    logic mdc_s1, mdc_s2, mdc_d3, mdio_s1, mdio_s2;
    logic rise;

    mdio_state_e state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d, shift_in;
    logic        is_read_q, is_read_d;
    logic        match_q, match_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] rdata_q, rdata_d;
    logic        oe_q, oe_d, out_q, out_d;
    logic        wr_fire, soft_rst;
    logic        reg_wr_q;
    logic [4:0]  reg_addr_q;
    logic [15:0] reg_wdata_q;
    logic [15:0] rf_rdata;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d3  <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= MDC;
            mdc_s2  <= mdc_s1;
            mdc_d3  <= mdc_s2;
            mdio_s1 <= MDIO;
            mdio_s2 <= mdio_s1;
        end
    end

    assign rise     = mdc_s2 & ~mdc_d3;
    assign shift_in = {shift_q[14:0], mdio_s2};

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        is_read_d = is_read_q;
        match_d   = match_q;
        regad_d   = regad_q;
        rdata_d   = rdata_q;
        oe_d      = oe_q;
        out_d     = out_q;
        wr_fire   = 1'b0;
        if (rise) begin
            shift_d = shift_in;
            unique case (state_q)
                StHunt: begin
                    if (mdio_s2) begin
                        if (pre_cnt_q != 6'(PREAMBLE_LEN)) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        if (pre_cnt_q == 6'(PREAMBLE_LEN) && mdio_s2 == ST_PATTERN[1]) begin
                            state_d = StSt;
                        end
                        pre_cnt_d = '0;
                    end
                end
                StSt: begin
                    bit_cnt_d = '0;
                    state_d   = (mdio_s2 == ST_PATTERN[0]) ? StOp : StHunt;
                end
                StOp: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(OP_W - 1)) begin
                        bit_cnt_d = '0;
                        is_read_d = (shift_in[1:0] == OP_READ);
                        if (shift_in[1:0] == OP_READ || shift_in[1:0] == OP_WRITE) begin
                            state_d = StPhyad;
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                StPhyad: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(PHYAD_W - 1)) begin
                        bit_cnt_d = '0;
                        match_d   = (shift_in[4:0] == PHY_ADDR);
                        state_d   = StRegad;
                    end
                end
                StRegad: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(REGAD_W - 1)) begin
                        bit_cnt_d = '0;
                        regad_d   = shift_in[4:0];
                        rdata_d   = rf_rdata;
                        state_d   = StTa;
                    end
                end
                StTa: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0) begin
                        // Second TA bit is ours to drive low on a matched read.
                        if (is_read_q && match_q) begin
                            oe_d  = 1'b1;
                            out_d = 1'b0;
                        end
                    end else if (bit_cnt_q == 4'(TA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            state_d = StData;
                            if (oe_q) begin
                                out_d   = rdata_q[15];
                                rdata_d = {rdata_q[14:0], 1'b0};
                            end
                        end else begin
                            state_d = (shift_in[1:0] == TA_WRITE) ? StData : StHunt;
                        end
                    end
                end
                StData: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StHunt;
                        oe_d      = 1'b0;
                        out_d     = 1'b0;
                        wr_fire   = !is_read_q && match_q;
                    end else if (oe_q) begin
                        out_d   = rdata_q[15];
                        rdata_d = {rdata_q[14:0], 1'b0};
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StHunt;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            regad_q     <= '0;
            rdata_q     <= '0;
            oe_q        <= 1'b0;
            out_q       <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            is_read_q <= is_read_d;
            match_q   <= match_d;
            regad_q   <= regad_d;
            rdata_q   <= rdata_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            reg_wr_q  <= wr_fire;
            if (wr_fire) begin
                reg_addr_q  <= regad_q;
                reg_wdata_q <= shift_in;
            end
        end
    end

    assign soft_rst = wr_fire && (regad_q == 5'd0) && shift_in[15];

    mdio_regfile u_regfile (
        .clk      (CLK),
        .rst_n    (RST_N),
        .soft_rst (soft_rst),
        .we       (wr_fire),
        .waddr    (regad_q),
        .wdata    (shift_in),
        .raddr    (shift_in[4:0]),
        .rdata    (rf_rdata)
    );

    assign MDIO          = oe_q ? out_q : 1'bz;
    assign bus.mdio_oe   = oe_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.busy      = (state_q != StHunt) && (state_q != StSt);

endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: directed MDIO frames, read/write monitors.
module tb_mdio_responder;
    import mdio_pkg::*;

    typedef struct packed {
        logic        abort;
        logic [15:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mdc;
    logic st_oe, st_out;
    wire  mdio;

    int checks = 0;
    int errors = 0;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    mdio_responder_if bus ();

    assign mdio = st_oe ? st_out : 1'bz;

    mdio_responder #(.PHY_ADDR(5'd1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .MDC   (mdc),
        .MDIO  (mdio),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit();
        tick(8);
        mdc = 1'b1;
        tick(8);
        mdc = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        st_out = b;
        clk_bit();
    endtask

    task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra);
        st_oe = 1'b1;
        repeat (pre) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 1; i >= 0; i--) send_bit(op[i]);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
    endtask

    task automatic do_read(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                           input logic exp_busy, input logic exp_resp,
                           input logic [15:0] exp_data, input int abort_at);
        rd_exp_t e;
        if (exp_resp) begin
            e.abort = (abort_at >= 0);
            e.data  = exp_data;
            rd_q.push_back(e);
        end
        send_hdr(pre, OP_READ, phy, ra);
        st_oe = 1'b0;
        check("busy_mid_read", 32'(bus.busy), 32'(exp_busy));
        clk_bit();
        clk_bit();
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                tick(4);
                if (exp_resp) check("drive_before_abort", 32'(bus.mdio_oe), 32'd1);
                rst_n = 1'b0;
                tick(1);
                check("abort_release", 32'(bus.mdio_oe), 32'd0);
                check("abort_busy", 32'(bus.busy), 32'd0);
                rst_n  = 1'b1;
                st_oe  = 1'b1;
                st_out = 1'b1;
                return;
            end
            clk_bit();
        end
        st_oe  = 1'b1;
        st_out = 1'b1;
        check("busy_end_read", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_write(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] data, input logic [1:0] ta,
                            input logic exp_busy, input logic exp_wr, input int abort_at);
        wr_exp_t w;
        if (exp_wr) begin
            w.addr = ra;
            w.data = data;
            wr_q.push_back(w);
        end
        send_hdr(pre, OP_WRITE, phy, ra);
        check("busy_mid_write", 32'(bus.busy), 32'(exp_busy));
        send_bit(ta[1]);
        send_bit(ta[0]);
        for (int i = 15; i >= 0; i--) begin
            if (15 - i == abort_at) begin
                tick(4);
                rst_n = 1'b0;
                tick(1);
                check("wabort_busy", 32'(bus.busy), 32'd0);
                rst_n  = 1'b1;
                st_out = 1'b1;
                return;
            end
            send_bit(data[i]);
        end
        st_out = 1'b1;
        check("busy_end_write", 32'(bus.busy), 32'd0);
    endtask

    // res: 0 = MDC rose, 1 = responder released MDIO, 2 = timed out
    task automatic wait_rise(output int res);
        logic prev;
        prev = mdc;
        res  = 2;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!bus.mdio_oe) begin
                res = 1;
                return;
            end
            if (mdc && !prev) begin
                res = 0;
                return;
            end
            prev = mdc;
        end
    endtask

    initial begin : rd_mon
        rd_exp_t     e;
        logic [16:0] bits;
        logic        ab;
        int          res;
        forever begin
            @(negedge clk);
            if (bus.mdio_oe) begin
                check("ta_drive0", 32'(mdio), 32'd0);
                bits = '0;
                ab   = 1'b0;
                for (int i = 0; i < 17; i++) begin
                    wait_rise(res);
                    if (res != 0) begin
                        ab = 1'b1;
                        break;
                    end
                    bits = {bits[15:0], mdio};
                end
                if (!ab) begin
                    repeat (6) @(negedge clk);
                    check("release_after_d0", 32'(bus.mdio_oe), 32'd0);
                end
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_drive: got read data %h, expected no response",
                             bits[15:0]);
                end else begin
                    e = rd_q.pop_front();
                    check("read_aborted", 32'(ab), 32'(e.abort));
                    if (!e.abort && !ab) begin
                        check("ta_bit2", 32'(bits[16]), 32'd0);
                        check("read_data", 32'(bits[15:0]), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin : wr_mon
        wr_exp_t w;
        forever begin
            @(negedge clk);
            if (bus.reg_wr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected none",
                             bus.reg_addr, bus.reg_wdata);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(bus.reg_addr), 32'(w.addr));
                    check("wr_data", 32'(bus.reg_wdata), 32'(w.data));
                end
                @(negedge clk);
                check("wr_pulse_width", 32'(bus.reg_wr), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got no completion, expected the bench to finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n  = 1'b0;
        mdc    = 1'b0;
        st_oe  = 1'b1;
        st_out = 1'b1;
        tick(4);
        check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_oe", 32'(bus.mdio_oe), 32'd0);
        rst_n = 1'b1;
        tick(2);

        do_read(32, 5'd1, 5'd2, 1'b1, 1'b1, 16'h0022, -1);
        do_write(32, 5'd1, 5'd5, 16'hBEEF, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd5, 1'b1, 1'b1, 16'hBEEF, -1);
        // Foreign PHY address: tracked silently.
        do_read(32, 5'd2, 5'd0, 1'b1, 1'b0, 16'h0000, -1);
        do_write(32, 5'd2, 5'd4, 16'h1111, 2'b10, 1'b1, 1'b0, -1);
        // Short preamble is ignored, full one answered.
        do_read(31, 5'd1, 5'd0, 1'b0, 1'b0, 16'h0000, -1);
        do_read(32, 5'd1, 5'd1, 1'b1, 1'b1, 16'h7949, -1);
        // Soft reset via reg0 bit15.
        do_write(32, 5'd1, 5'd4, 16'h1234, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd4, 1'b1, 1'b1, 16'h1234, -1);
        do_write(32, 5'd1, 5'd0, 16'h8000, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd0, 1'b1, 1'b1, 16'h1140, -1);
        do_read(32, 5'd1, 5'd4, 1'b1, 1'b1, 16'h0000, -1);
        do_write(32, 5'd1, 5'd0, 16'h3100, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd0, 1'b1, 1'b1, 16'h3100, -1);
        // RO and unimplemented registers pulse reg_wr but keep their contents.
        do_write(32, 5'd1, 5'd1, 16'hAAAA, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd1, 1'b1, 1'b1, 16'h7949, -1);
        do_write(32, 5'd1, 5'd9, 16'h7777, 2'b10, 1'b1, 1'b1, -1);
        do_read(32, 5'd1, 5'd9, 1'b1, 1'b1, 16'h0000, -1);
        // Bad write turnaround drops the frame.
        do_write(32, 5'd1, 5'd6, 16'hABCD, 2'b10, 1'b1, 1'b1, -1);
        do_write(32, 5'd1, 5'd6, 16'h5555, 2'b11, 1'b1, 1'b0, -1);
        do_read(32, 5'd1, 5'd6, 1'b1, 1'b1, 16'hABCD, -1);
        // Reset while D8 is on the wire.
        do_read(32, 5'd1, 5'd2, 1'b1, 1'b1, 16'h0022, 7);
        check("post_abort_addr", 32'(bus.reg_addr), 32'd0);
        check("post_abort_wdata", 32'(bus.reg_wdata), 32'd0);
        tick(2);
        do_read(32, 5'd1, 5'd3, 1'b1, 1'b1, 16'h1622, -1);
        do_read(32, 5'd1, 5'd0, 1'b1, 1'b1, 16'h1140, -1);
        do_read(32, 5'd1, 5'd6, 1'b1, 1'b1, 16'h0000, -1);
        // Reset mid write data: nothing commits.
        do_write(32, 5'd1, 5'd6, 16'h4321, 2'b10, 1'b1, 1'b0, 10);
        tick(2);
        do_read(32, 5'd1, 5'd6, 1'b1, 1'b1, 16'h0000, -1);

        tick(60);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter: PHY_ADDR, default 5'd1, PHY address to which this responder answers.
REQ-002 SHALL have port: CLK  input  1  system clock, at least 8x MDC frequency; all logic on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port: MDC  input  1  management clock from the station, asynchronous to CLK.
REQ-005 SHALL have port: MDIO  inout  1  management data; driven only while responding to a read, high-Z otherwise.
REQ-006 SHALL have port: reg_wr  output  1  one-CLK pulse when a register write commits.
REQ-007 SHALL have port: reg_addr  output  5  register address of the last committed write.
REQ-008 SHALL have port: reg_wdata  output  16  data of the last committed write.
REQ-009 SHALL have port: busy  output  1  high from a valid ST through the end of the frame.

Function
REQ-010 SHALL synchronise MDC and MDIO input through 2 flops each; a "rise event" is a CLK cycle where synchronised MDC goes 0->1; every MDIO bit is sampled at a rise event.
REQ-011 SHALL implement states HUNT, ST, OP, PHYAD, REGAD, TA, DATA; Clause-22 frame order, MSB first.
REQ-012 HUNT: count consecutive sampled 1s (saturating at 32); a 0 before 32 clears the count; a 0 with count = 32 is ST bit 1 -> ST.
REQ-013 ST: the next bit SHALL be 1 -> OP, with busy set; otherwise -> HUNT with count 0.
REQ-014 OP: 2'b10 = read, 2'b01 = write; 00/11 -> HUNT with count 0, no response.
REQ-015 PHYAD 5 bits, then REGAD 5 bits; match = (PHYAD == PHY_ADDR).
REQ-016 Read with match: at the cycle after the rise event sampling TA bit 1, MDIO SHALL drive 0; at each following rise event, the next cycle SHALL drive D15, D14 ... D0 in turn; the cycle after the rise event where the station samples D0, MDIO SHALL return to high-Z.
REQ-017 Read data SHALL be captured from the register file at the rise event sampling the last REGAD bit.
REQ-018 Write: TA bits SHALL be 2'b10, else -> HUNT without write; then 16 data bits are shifted in.
REQ-019 Write with match: on the rise event of D0, the write SHALL commit next cycle, with reg_wr = 1 for exactly one CLK and reg_addr/reg_wdata updated; writes to read-only or unimplemented registers still pulse reg_wr but leave the register file unchanged.
REQ-020 No match: the frame SHALL be tracked to its end silently, with MDIO high-Z and no reg_wr.
REQ-021 After any frame end or abort, SHALL return to HUNT with count 0 and busy = 0; every frame needs a fresh 32-bit preamble.
REQ-022 Register map:
- reg0 RW, reset 16'h1140.
- reg1 RO, 16'h7949.
- reg2 RO, 16'h0022.
- reg3 RO, 16'h1622.
- reg4-7 RW, reset 16'h0000.
- regs 8-31 read 16'h0000.
REQ-023 Writing reg0 with bit15 = 1 SHALL restore reg0 and reg4-7 to reset values; reg0 bit15 always reads 0.

Reset
REQ-024 On a CLK edge with RST_N = 0:
- MDIO high-Z.
- reg_wr = 0, reg_addr = 0, reg_wdata = 0, busy = 0.
- State HUNT, count 0.
- Registers at reset values.
- Synchronisers cleared.
REQ-025 RST_N low mid-frame SHALL abort the frame, including mid-read drive, releasing MDIO on that edge; no partial write SHALL commit.

Structure
REQ-026 Package mdio_pkg SHALL hold:
- the state enum;
- opcode constants OP_READ/OP_WRITE;
- ST pattern, preamble length 32, field widths;
- register reset/RO values.
REQ-027 Register storage SHALL be sub-module mdio_regfile (8x16, one read port, one write port, soft-reset input); framing, tristate and synchronisers stay in mdio_responder.

Verification
REQ-028 Read reg2 at PHY_ADDR 1 after reset -> TA drive 0, then MDIO serialises 16'h0022 MSB first; high-Z after D0.
REQ-029 Write 16'hBEEF to reg5, then read reg5 -> reg_wr pulses once with reg_addr = 5, reg_wdata = 16'hBEEF; read returns 16'hBEEF.
REQ-030 Read reg0 at PHYAD 2 -> MDIO never driven; no reg_wr; busy still covers the frame.
REQ-031 31-bit preamble, then a valid read -> no response; then a 32-bit preamble read of reg1 -> 16'h7949.
REQ-032 Write 16'h8000 to reg0 after writing 16'h1234 to reg4 -> reg0 reads 16'h1140, reg4 reads 16'h0000.
REQ-033 RST_N low during read data bit D8 -> MDIO high-Z on that edge; the next full read of reg3 returns 16'h1622.
